// File: rtl/dac_voice_scheduler.sv
// dac_voice_scheduler: mixes NUM_VOICES voice samples into one saturated codec DAC write per frame.
// Optional macro UNDERRUN_COUNT_EN adds a saturating 16-bit underrun_count output.
module dac_voice_scheduler #(
  parameter int NUM_VOICES = 4,
  parameter int DATA_W     = 24,
  parameter int TIMEOUT    = 64
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [NUM_VOICES-1:0]        voice_en,
  input  logic [NUM_VOICES-1:0]        voice_valid,
  input  logic [NUM_VOICES*DATA_W-1:0] voice_data,
  output logic [NUM_VOICES-1:0]        voice_ready,
  input  logic                         write_ready,
  output logic                         write,
  output logic [DATA_W-1:0]            writedata_left,
  output logic [DATA_W-1:0]            writedata_right,
  output logic                         busy,
  output logic                         underrun,
  output logic                         clip
`ifdef UNDERRUN_COUNT_EN
  ,
  output logic [15:0]                  underrun_count
`endif
);

  localparam int ACC_W = DATA_W + $clog2(NUM_VOICES) + 1;
  localparam int IDX_W = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;
  localparam int WC_W  = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam int EXT_W = ACC_W - DATA_W;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_VOICES - 1);
  localparam logic [WC_W-1:0]  WC_LAST  = WC_W'(TIMEOUT - 1);

  localparam logic signed [ACC_W-1:0] MAX_V =
    {{(EXT_W + 1){1'b0}}, {(DATA_W - 1){1'b1}}};
  localparam logic signed [ACC_W-1:0] MIN_V =
    {{(EXT_W + 1){1'b1}}, {(DATA_W - 1){1'b0}}};

  typedef enum logic [1:0] {
    IDLE,
    COLLECT,
    SAT,
    WRITE
  } state_t;

  state_t state;
  state_t state_nxt;

  logic [NUM_VOICES-1:0]     en_q;
  logic [IDX_W-1:0]          idx;
  logic [WC_W-1:0]           wait_cnt;
  logic signed [ACC_W-1:0]   acc;

  logic [DATA_W-1:0]         sample;
  logic signed [ACC_W-1:0]   sample_x;
  logic                      cur_en;
  logic                      cur_valid;
  logic                      consume;
  logic                      expired;
  logic                      advance;
  logic                      last_adv;
  logic                      sat_hi;
  logic                      sat_lo;
  logic [DATA_W-1:0]         sat_val;
  logic [DATA_W-1:0]         max_d;
  logic [DATA_W-1:0]         min_d;

  // Select the sample, enable and valid of the voice under scan
  always_comb begin
    sample    = '0;
    cur_en    = 1'b0;
    cur_valid = 1'b0;
    for (int i = 0; i < NUM_VOICES; i++) begin
      if (idx == IDX_W'(i)) begin
        sample    = voice_data[i*DATA_W +: DATA_W];
        cur_en    = en_q[i];
        cur_valid = voice_valid[i];
      end
    end
  end

  assign sample_x = {{EXT_W{sample[DATA_W-1]}}, sample};

  // A valid sample wins over an expiring wait on the same cycle
  assign consume  = cur_en && cur_valid;
  assign expired  = cur_en && !cur_valid && (wait_cnt == WC_LAST);
  assign advance  = !cur_en || cur_valid || (wait_cnt == WC_LAST);
  assign last_adv = advance && (idx == LAST_IDX);

  assign max_d   = MAX_V[DATA_W-1:0];
  assign min_d   = MIN_V[DATA_W-1:0];
  assign sat_hi  = acc > MAX_V;
  assign sat_lo  = acc < MIN_V;
  assign sat_val = sat_hi ? max_d :
                   sat_lo ? min_d : acc[DATA_W-1:0];

  // FSM state register
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // FSM next-state logic
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    state_nxt = COLLECT;
      COLLECT: if (last_adv) state_nxt = SAT;
      SAT:     state_nxt = WRITE;
      WRITE:   if (write_ready) state_nxt = COLLECT;
      default: state_nxt = IDLE;
    endcase
  end

  // FSM outputs: handshake strobes and busy
  always_comb begin
    voice_ready = '0;
    write       = 1'b0;
    busy        = (state != IDLE);
    unique case (state)
      COLLECT: if (consume) voice_ready[idx] = 1'b1;
      WRITE:   write = write_ready;
      default: ;
    endcase
  end

  // Frame datapath: enable latch, scan index, wait timer, accumulator, result
  always_ff @(posedge clk) begin
    if (reset) begin
      en_q            <= '0;
      idx             <= '0;
      wait_cnt        <= '0;
      acc             <= '0;
      writedata_left  <= '0;
      writedata_right <= '0;
      underrun        <= 1'b0;
      clip            <= 1'b0;
    end else begin
      underrun <= 1'b0;
      clip     <= 1'b0;
      unique case (state)
        IDLE: begin
          en_q     <= voice_en;
          idx      <= '0;
          wait_cnt <= '0;
          acc      <= '0;
        end
        COLLECT: begin
          if (consume) begin
            acc <= acc + sample_x;
          end
          if (advance) begin
            wait_cnt <= '0;
            idx      <= last_adv ? '0 : idx + IDX_W'(1);
          end else begin
            wait_cnt <= wait_cnt + WC_W'(1);
          end
          if (expired) begin
            underrun <= 1'b1;
          end
        end
        SAT: begin
          writedata_left  <= sat_val;
          writedata_right <= sat_val;
          clip            <= sat_hi || sat_lo;
        end
        WRITE: begin
          if (write_ready) begin
            en_q     <= voice_en;
            idx      <= '0;
            wait_cnt <= '0;
            acc      <= '0;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef UNDERRUN_COUNT_EN
  // Saturating tally of underrun pulses since reset
  always_ff @(posedge clk) begin
    if (reset) begin
      underrun_count <= '0;
    end else if (underrun && (underrun_count != 16'hFFFF)) begin
      underrun_count <= underrun_count + 16'd1;
    end
  end
`endif

endmodule
